apb_req_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single APB master request port (SWRITE/SADDR/SWDATA/SSTRB/SPROT/transfer)

---
 rtl/apb_req_arbiter.sv | 120 ++++++++++++
 tb/tb_apb_req_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter sharing one APB master request port among NUM_REQ requesters
// Build option: APB_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic [NUM_REQ-1:0]             r_valid,
  input  logic [NUM_REQ-1:0]             r_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  r_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  r_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]  r_strb,
  input  logic [NUM_REQ*3-1:0]           r_prot,
  output logic [NUM_REQ-1:0]             r_grant,
  output logic [NUM_REQ-1:0]             r_done,
  output logic [DATA_WIDTH-1:0]          r_rdata,
  output logic                           r_slverr,
  output logic                           SWRITE,
  output logic [ADDR_WIDTH-1:0]          SADDR,
  output logic [DATA_WIDTH-1:0]          SWDATA,
  output logic [STRB_WIDTH-1:0]          SSTRB,
  output logic [2:0]                     SPROT,
  output logic                           transfer,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PREADY,
  input  logic                           PSLVERR,
  input  logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win_idx;
  logic          win_found;
  int            idx;

  // Search starts at rr_ptr and wraps explicitly so non-power-of-two NUM_REQ never reaches bits >= NUM_REQ.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && r_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
      SWRITE   <= 1'b0;
      SADDR    <= '0;
      SWDATA   <= '0;
      SSTRB    <= '0;
      SPROT    <= '0;
      transfer <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          r_done <= '0;
          if (win_found) begin
            SWRITE   <= r_write[win_idx];
            SADDR    <= r_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            SWDATA   <= r_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
            SSTRB    <= r_strb[win_idx*STRB_WIDTH +: STRB_WIDTH];
            SPROT    <= r_prot[win_idx*3 +: 3];
            r_grant  <= NUM_REQ'(1) << win_idx;
            owner    <= win_idx;
            transfer <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (PSEL && PENABLE && PREADY) begin
            r_rdata  <= SWRITE ? '0 : PRDATA;
            r_slverr <= PSLVERR;
            transfer <= 1'b0;
            r_done   <= r_grant;
            state    <= RESP;
          end
        end
        RESP: begin
          r_done  <= '0;
          r_grant <= '0;
          busy    <= 1'b0;
`ifdef APB_ARB_FIXED_PRIO_EN
          rr_ptr  <= '0;
`else
          rr_ptr  <= (owner == PW'(NUM_REQ-1)) ? '0 : owner + 1'b1;
`endif
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - directed self-checking bench for apb_req_arbiter
// Expectations switch to fixed priority when APB_ARB_FIXED_PRIO_EN is defined.
module tb_apb_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [N-1:0]    r_valid, r_write;
  logic [N*AW-1:0] r_addr;
  logic [N*DW-1:0] r_wdata;
  logic [N*SW-1:0] r_strb;
  logic [N*3-1:0]  r_prot;
  logic [N-1:0]    r_grant, r_done;
  logic [DW-1:0]   r_rdata;
  logic            r_slverr;
  logic            SWRITE;
  logic [AW-1:0]   SADDR;
  logic [DW-1:0]   SWDATA;
  logic [SW-1:0]   SSTRB;
  logic [2:0]      SPROT;
  logic            transfer;
  logic            PSEL, PENABLE, PREADY, PSLVERR;
  logic [DW-1:0]   PRDATA;
  logic            busy;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_g;

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .r_valid(r_valid), .r_write(r_write), .r_addr(r_addr), .r_wdata(r_wdata),
    .r_strb(r_strb), .r_prot(r_prot),
    .r_grant(r_grant), .r_done(r_done), .r_rdata(r_rdata), .r_slverr(r_slverr),
    .SWRITE(SWRITE), .SADDR(SADDR), .SWDATA(SWDATA), .SSTRB(SSTRB), .SPROT(SPROT),
    .transfer(transfer),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic step;
    @(negedge PCLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    r_write[i]        = wr;
    r_addr[i*AW +: AW] = a;
    r_wdata[i*DW +: DW] = d;
    r_strb[i*SW +: SW] = 4'hF;
    r_prot[i*3 +: 3]   = 3'(i);
  endtask

  // Called in ISSUE; returns at the negedge of RESP (completion edge just passed).
  task automatic bus(input int waits, input logic [31:0] rd, input logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PREADY = 1'b0;
    step;
    PENABLE = 1'b1; PRDATA = rd; PSLVERR = err;
    for (int i = 0; i < waits; i++) begin
      PREADY = 1'b0;
      step;
    end
    PREADY = 1'b1;
    step;
    PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
  endtask

  initial begin
    PRESET = 1'b1;
    r_valid = '0; r_write = '0; r_addr = '0; r_wdata = '0; r_strb = '0; r_prot = '0;
    PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    step; step;
    chk("rst_transfer", 64'(transfer), 64'h0);
    chk("rst_grant", 64'(r_grant), 64'h0);
    chk("rst_done", 64'(r_done), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rdata", 64'(r_rdata), 64'h0);
    chk("rst_saddr", 64'(SADDR), 64'h0);
    PRESET = 1'b0;
    step;
    chk("idle_busy", 64'(busy), 64'h0);

    // Single write from req0
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
    r_valid = 4'b0001;
    step;
    chk("t1_transfer", 64'(transfer), 64'h1);
    chk("t1_grant", 64'(r_grant), 64'h1);
    chk("t1_saddr", 64'(SADDR), 64'h10);
    chk("t1_swdata", 64'(SWDATA), 64'hDEADBEEF);
    chk("t1_swrite", 64'(SWRITE), 64'h1);
    chk("t1_busy", 64'(busy), 64'h1);
    bus(0, 32'h0, 1'b0);
    chk("t1_done", 64'(r_done), 64'h1);
    chk("t1_slverr", 64'(r_slverr), 64'h0);
    chk("t1_grant_resp", 64'(r_grant), 64'h1);
    chk("t1_transfer_off", 64'(transfer), 64'h0);
    r_valid = '0;
    step;
    chk("t1_done_pulse", 64'(r_done), 64'h0);
    chk("t1_grant_clr", 64'(r_grant), 64'h0);
    chk("t1_busy_clr", 64'(busy), 64'h0);

    // Read from req2 with two wait states
    set_req(2, 1'b0, 32'h20, 32'h0);
    r_valid = 4'b0100;
    step;
    chk("t2_grant", 64'(r_grant), 64'h4);
    chk("t2_saddr", 64'(SADDR), 64'h20);
    chk("t2_swrite", 64'(SWRITE), 64'h0);
    chk("t2_sprot", 64'(SPROT), 64'h2);
    bus(2, 32'h12345678, 1'b0);
    chk("t2_done", 64'(r_done), 64'h4);
    chk("t2_rdata", 64'(r_rdata), 64'h12345678);
    r_valid = '0;
    step;
    chk("t2_rdata_hold", 64'(r_rdata), 64'h12345678);

    // Contention from a fresh pointer: all four held
    PRESET = 1'b1;
    step;
    PRESET = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + 32'(i*4), 32'hA0 + 32'(i));
    r_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef APB_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (k % 4);
`endif
      step;
      chk("t3_grant", 64'(r_grant), 64'(exp_g));
      chk("t3_transfer", 64'(transfer), 64'h1);
      bus(k % 2, 32'h0, 1'b0);
      chk("t3_done", 64'(r_done), 64'(exp_g));
      step;
      chk("t3_done_clr", 64'(r_done), 64'h0);
    end
    r_valid = '0;
    step;

    // Slave error on req1 write; write captures zero read data
    set_req(1, 1'b1, 32'h40, 32'hCAFE0001);
    r_valid = 4'b0010;
    step;
    chk("t4_grant", 64'(r_grant), 64'h2);
    bus(1, 32'hBAD0BAD0, 1'b1);
    chk("t4_done", 64'(r_done), 64'h2);
    chk("t4_slverr", 64'(r_slverr), 64'h1);
    chk("t4_rdata_wr", 64'(r_rdata), 64'h0);
    r_valid = '0;
    step;
    r_valid = 4'b0010;
    step;
    chk("t4b_grant", 64'(r_grant), 64'h2);
    // Drop request and change fields after grant: must be ignored
    r_valid = '0;
    r_addr[1*AW +: AW] = 32'hFFF0;
    bus(0, 32'h0, 1'b0);
    chk("t4b_done", 64'(r_done), 64'h2);
    chk("t4b_slverr", 64'(r_slverr), 64'h0);
    chk("t4b_saddr", 64'(SADDR), 64'h40);
    step;

    // Reset while waiting on the bus
    r_valid = 4'b1000;
    step;
    PSEL = 1'b1;
    step;
    chk("t5_transfer", 64'(transfer), 64'h1);
    PRESET = 1'b1;
    step;
    chk("t5_transfer_off", 64'(transfer), 64'h0);
    chk("t5_grant", 64'(r_grant), 64'h0);
    chk("t5_done", 64'(r_done), 64'h0);
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_saddr", 64'(SADDR), 64'h0);
    PRESET = 1'b0; PSEL = 1'b0;
    r_valid = 4'b1001;
    step;
    chk("t5_regrant", 64'(r_grant), 64'h1);
    bus(0, 32'h0, 1'b0);
    chk("t5_done2", 64'(r_done), 64'h1);
    r_valid = '0;
    step;

    // Requesters 1 and 3 held
    r_valid = 4'b1010;
    step;
    chk("t6_grant1", 64'(r_grant), 64'h2);
    bus(0, 32'h0, 1'b0);
    chk("t6_done1", 64'(r_done), 64'h2);
    step;
    step;
`ifdef APB_ARB_FIXED_PRIO_EN
    exp_g = 4'b0010;
`else
    exp_g = 4'b1000;
`endif
    chk("t6_grant2", 64'(r_grant), 64'(exp_g));
    bus(0, 32'h0, 1'b0);
    r_valid = 4'b1000;
    step;
    step;
    chk("t6_grant3", 64'(r_grant), 64'h8);
    bus(0, 32'h0, 1'b0);
    chk("t6_done3", 64'(r_done), 64'h8);
    r_valid = '0;
    step;
    chk("t6_busy_end", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
